interrupt_request_capture: RTL
==============================

Name: interrupt_request_capture

Overview:
Front-end stage that feeds the priority interrupt controller's `req` vector. It takes raw, asynchronous per-source interrupt lines and synchronises each one to `clk`. Each source is then qualified as edge- or level-triggered, and edge events are latched as pending until the controller's one-hot `ack` retires them. Per-source masking and sticky overflow flags (lost edges) are provided for software visibility.

Parameters:
- NINTR, 4, number of interrupt sources (≥2).
- SYNC_STAGES, 2, flops in each input synchroniser chain (≥2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- irq_in  input  NINTR  raw asynchronous interrupt lines from peripherals.
- edge_mode  input  NINTR  per source: 1 = rising-edge triggered, 0 = level triggered; quasi-static.
- mask  input  NINTR  per source: 1 = enabled to reach `req`, 0 = blocked.
- ack  input  NINTR  acknowledge from the interrupt controller; one-hot in normal use, but any pattern is legal.
- ovf_clr  input  NINTR  per-bit clear of the overflow flags; single-cycle pulse.
- req  output  NINTR  masked pending vector to the controller; `req = pending & mask`, combinational from registers.
- pending  output  NINTR  unmasked pending state, registered.
- overflow  output  NINTR  sticky flag: an edge arrived while that source was already pending.

Behaviour:
- Reset (reset=1 at a clk edge) clears:
  - all synchroniser flops;
  - the edge-history register `sync_prev`;
  - the mode-history register `mode_prev`;
  - `pending`, `overflow`, and therefore `req`.
- Reset takes priority over every other input on the same edge.
- Synchroniser:
  - irq_in[i] passes through SYNC_STAGES flops; `s[i]` denotes the last stage.
  - `sync_prev[i] <= s[i]` every cycle.
  - `rise[i] = s[i] & ~sync_prev[i]`.
- Edge mode (edge_mode[i]=1), next pending[i], in priority order:
  1. mode changed this cycle (`edge_mode[i] != mode_prev[i]`) → 0;
  2. `rise[i]` → 1;
  3. `ack[i]` → 0;
  4. otherwise hold.
  - Rise and ack on the same edge: pending stays 1, so the new event is not lost.
  - overflow[i] sets when `rise[i] & pending[i] & ~ack[i]`.
- Level mode (edge_mode[i]=0), next pending[i]:
  - mode changed → 0; otherwise `pending[i] <= s[i]`.
  - ack[i] is ignored; the source must deassert its own line.
  - overflow[i] is never set in level mode.
- Overflow clear:
  - `ovf_clr[i]` clears overflow[i].
  - If a set condition and ovf_clr occur on the same edge, set wins.
- `mode_prev <= edge_mode` every cycle.
  - A mode switch therefore discards that source's pending bit for exactly one cycle.
  - Normal capture resumes on the following cycle.
- Masking:
  - Masked sources still latch pending and overflow.
  - Unmasking exposes an already-pending bit on `req` in the same cycle (combinational).
- Latency: a stable high on irq_in sampled at edge E gives:
  - s high after edge E+SYNC_STAGES−1;
  - pending high after edge E+SYNC_STAGES;
  - for SYNC_STAGES=2, `req` rises 2 cycles after first sampling, provided mask=1.
- Pulses on irq_in shorter than one clk period may be missed; this is a source requirement, not an error.
- A line that is already high when reset releases is seen as a rising edge, because sync_prev resets to 0. It is captured once in edge mode.
- Bits are fully independent. Multi-bit ack clears every addressed edge-mode source.

Test Plan:
1. Reset with all inputs 0, then `irq_in=4'b0100`, edge_mode=4'hF, mask=4'hF. Required: pending=req=4'b0100 exactly 2 cycles after first sample. Then ack=4'b0100 for 1 cycle. Required: pending=0 next cycle while irq_in stays high (no re-trigger).
2. Edge source 0 pending, second rising edge on irq_in[0] without ack. Required: overflow=4'b0001 sticky. Then ovf_clr=4'b0001. Required: overflow=0 next cycle. Repeat with set and ovf_clr on the same edge. Required: overflow stays 1.
3. Edge source 1: align a new rise with ack[1]=1 on the same edge. Required: pending[1] stays 1 and overflow[1] stays 0.
4. Level source 3 (edge_mode[3]=0): irq_in[3] high for 5 cycles while ack[3] is pulsed. Required: pending[3] tracks the line with 2-cycle lag and is unaffected by ack.
5. mask=4'b0000 with an edge on source 2. Required: pending=4'b0100, req=0. Set mask[2]=1. Required: req=4'b0100 the same cycle.
6. Source 1 pending in edge mode, then toggle edge_mode[1] to 0 while irq_in[1]=0. Required: pending[1]=0 next cycle. Also assert reset mid-stream with sources pending. Required: all outputs 0 the next cycle.

Source files
------------

// File: rtl/interrupt_request_capture_if.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_request_capture_if
//  Description : Signal bundle between the interrupt sources / software side
//                and the interrupt request capture stage.
//                  irq_in    - raw asynchronous interrupt lines
//                  edge_mode - per source: 1 = rising edge, 0 = level
//                  mask      - per source enable onto req
//                  ack       - acknowledge from the interrupt controller
//                  ovf_clr   - per-bit clear of the sticky overflow flags
//                  req       - pending & mask, to the interrupt controller
//                  pending   - unmasked pending state
//                  overflow  - sticky lost-edge flags
//                master : drives the inputs, observes the outputs
//                slave  : the capture stage itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface interrupt_request_capture_if #(
    parameter int NINTR = 4
);
    logic [NINTR-1:0] irq_in;
    logic [NINTR-1:0] edge_mode;
    logic [NINTR-1:0] mask;
    logic [NINTR-1:0] ack;
    logic [NINTR-1:0] ovf_clr;
    logic [NINTR-1:0] req;
    logic [NINTR-1:0] pending;
    logic [NINTR-1:0] overflow;

    modport master (
        output irq_in, edge_mode, mask, ack, ovf_clr,
        input  req, pending, overflow
    );

    modport slave (
        input  irq_in, edge_mode, mask, ack, ovf_clr,
        output req, pending, overflow
    );
endinterface
`default_nettype wire

// File: rtl/interrupt_request_capture.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_request_capture
//  Description : Front end of the priority interrupt controller. Each raw
//                interrupt line is synchronised to clk, qualified as edge or
//                level triggered, and held as pending until retired. Edge
//                events are retired by ack; level sources follow their line.
//                A rising edge on an edge source that is already pending (and
//                not being acknowledged) sets a sticky overflow flag.
//  Ports       : clk   - system clock, all state on the rising edge
//                reset - synchronous, active-high reset
//                bus   - interrupt_request_capture_if.slave bundle
//                        (irq_in, edge_mode, mask, ack, ovf_clr in;
//                         req, pending, overflow out)
//  Revision    : 1.0 - initial release
// ============================================================================
module interrupt_request_capture #(
    parameter int NINTR       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  wire                            clk,
    input  wire                            reset,
    interrupt_request_capture_if.slave     bus
);

    // Synchroniser chain: row 0 samples the raw line, the last row is the
    // synchronised value used by all downstream logic.
    logic [SYNC_STAGES-1:0][NINTR-1:0] r_sync;
    logic [NINTR-1:0]                  r_sync_prev;
    logic [NINTR-1:0]                  r_mode_prev;
    logic [NINTR-1:0]                  r_pending;
    logic [NINTR-1:0]                  r_overflow;

    logic [NINTR-1:0] w_sync;
    logic [NINTR-1:0] w_rise;
    logic [NINTR-1:0] w_mode_chg;
    logic [NINTR-1:0] w_pend_edge;
    logic [NINTR-1:0] w_pend_nxt;
    logic [NINTR-1:0] w_ovf_set;
    logic [NINTR-1:0] w_ovf_nxt;

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_rise     = w_sync & ~r_sync_prev;
    assign w_mode_chg = bus.edge_mode ^ r_mode_prev;

    // Edge sources: a rise beats a simultaneous ack so the new event survives.
    assign w_pend_edge = w_rise | (r_pending & ~bus.ack);

    // A mode switch discards the pending bit for one cycle in either mode.
    assign w_pend_nxt = ~w_mode_chg &
                        ((bus.edge_mode & w_pend_edge) | (~bus.edge_mode & w_sync));

    // Set has priority over a same-cycle clear so a lost edge is never hidden.
    assign w_ovf_set = bus.edge_mode & w_rise & r_pending & ~bus.ack;
    assign w_ovf_nxt = w_ovf_set | (r_overflow & ~bus.ovf_clr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync      <= '0;
            r_sync_prev <= '0;
            r_mode_prev <= '0;
            r_pending   <= '0;
            r_overflow  <= '0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], bus.irq_in};
            r_sync_prev <= w_sync;
            r_mode_prev <= bus.edge_mode;
            r_pending   <= w_pend_nxt;
            r_overflow  <= w_ovf_nxt;
        end
    end

    // Mask is applied after the register so unmasking is visible immediately.
    assign bus.req      = r_pending & bus.mask;
    assign bus.pending  = r_pending;
    assign bus.overflow = r_overflow;

endmodule
`default_nettype wire
